// File: rtl/demux2_fifo.sv
// 1-to-2 demultiplexer with one FIFO per destination. Each beat is steered by
// in_s into its destination FIFO, so a stalled consumer only blocks its own stream.
module demux2_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [AW:0]      cnt0,
    output logic [AW:0]      cnt1
);

    logic [WIDTH-1:0] r_mem  [2][DEPTH];
    logic [AW-1:0]    r_wptr [2];
    logic [AW-1:0]    r_rptr [2];
    logic [AW:0]      r_cnt  [2];

    logic [1:0] w_full;
    logic [1:0] w_valid;
    logic [1:0] w_push;
    logic [1:0] w_pop;

    // in_ready looks only at the selected FIFO's registered count, never at the
    // consumer readies, so a same-cycle pop cannot open a slot on a full FIFO.
    assign w_full[0]  = (r_cnt[0] == (AW+1)'(DEPTH));
    assign w_full[1]  = (r_cnt[1] == (AW+1)'(DEPTH));
    assign w_valid[0] = (r_cnt[0] != '0);
    assign w_valid[1] = (r_cnt[1] != '0);
    assign in_ready   = ~w_full[in_s] & ~flush;

    assign w_push[0] = in_valid & in_ready & ~in_s;
    assign w_push[1] = in_valid & in_ready &  in_s;
    assign w_pop[0]  = w_valid[0] & out0_ready;
    assign w_pop[1]  = w_valid[1] & out1_ready;

    always_ff @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (w_push[d]) begin
                r_mem[d][r_wptr[d]] <= in_data;
            end
        end
    end

    // Flush wins over any push or pop presented in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                r_wptr[d] <= '0;
                r_rptr[d] <= '0;
                r_cnt[d]  <= '0;
            end
        end else if (flush) begin
            for (int d = 0; d < 2; d++) begin
                r_wptr[d] <= '0;
                r_rptr[d] <= '0;
                r_cnt[d]  <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (w_push[d]) begin
                    r_wptr[d] <= r_wptr[d] + AW'(1);
                end
                if (w_pop[d]) begin
                    r_rptr[d] <= r_rptr[d] + AW'(1);
                end
                if (w_push[d] && !w_pop[d]) begin
                    r_cnt[d] <= r_cnt[d] + (AW+1)'(1);
                end else if (!w_push[d] && w_pop[d]) begin
                    r_cnt[d] <= r_cnt[d] - (AW+1)'(1);
                end
            end
        end
    end

    assign out0_valid = w_valid[0];
    assign out1_valid = w_valid[1];
    assign out0_data  = w_valid[0] ? r_mem[0][r_rptr[0]] : '0;
    assign out1_data  = w_valid[1] ? r_mem[1][r_rptr[1]] : '0;
    assign cnt0       = r_cnt[0];
    assign cnt1       = r_cnt[1];

endmodule

// File: tb/tb_demux2_fifo.sv
// Self-checking bench for demux2_fifo: directed scenarios with literal
// expectations, then random traffic compared against a queue-based model.
module tb_demux2_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int AW    = 1;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic [WIDTH-1:0] in_data;
    logic             in_s;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [AW:0]      cnt0;
    logic [AW:0]      cnt1;

    int checks = 0;
    int errors = 0;
    bit checkEn = 0;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];

    demux2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .in_data(in_data),
        .in_s(in_s),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out0_data(out0_data),
        .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .out1_data(out1_data),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .cnt0(cnt0),
        .cnt1(cnt1)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per destination, updated from the handshake rules.
    always @(posedge clk or negedge rst_n) begin : model
        bit p0, p1, o0, o1;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else if (flush) begin
            q0.delete();
            q1.delete();
        end else begin
            o0 = out0_ready && (q0.size() != 0);
            o1 = out1_ready && (q1.size() != 0);
            p0 = in_valid && !in_s && (q0.size() < DEPTH);
            p1 = in_valid &&  in_s && (q1.size() < DEPTH);
            if (o0) void'(q0.pop_front());
            if (o1) void'(q1.pop_front());
            if (p0) q0.push_back(in_data);
            if (p1) q1.push_back(in_data);
        end
    end

    // Every cycle, compare all outputs against the model state.
    always @(negedge clk) begin : compare
        logic [31:0] expReady;
        logic [31:0] expD0;
        logic [31:0] expD1;
        if (checkEn) begin
            expReady = (!flush && ((in_s ? q1.size() : q0.size()) < DEPTH)) ? 32'd1 : 32'd0;
            expD0 = (q0.size() != 0) ? q0[0] : 32'd0;
            expD1 = (q1.size() != 0) ? q1[0] : 32'd0;
            checkOutput("m_in_ready", 32'(in_ready), expReady);
            checkOutput("m_out0_valid", 32'(out0_valid), (q0.size() != 0) ? 32'd1 : 32'd0);
            checkOutput("m_out1_valid", 32'(out1_valid), (q1.size() != 0) ? 32'd1 : 32'd0);
            checkOutput("m_out0_data", out0_data, expD0);
            checkOutput("m_out1_data", out1_data, expD1);
            checkOutput("m_cnt0", 32'(cnt0), 32'(q0.size()));
            checkOutput("m_cnt1", 32'(cnt1), 32'(q1.size()));
        end
    end

    task automatic applyStimulus(input bit v, input bit s, input logic [31:0] d,
                                 input bit r0, input bit r1, input bit f);
        @(posedge clk);
        #1;
        in_valid   = v;
        in_s       = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        flush      = f;
    endtask

    task automatic waitCheck();
        @(negedge clk);
        #2;
    endtask

    initial begin
        rst_n = 0;
        flush = 0;
        in_valid = 0;
        in_s = 0;
        in_data = 0;
        out0_ready = 0;
        out1_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        checkEn = 1;

        waitCheck();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out0_valid", 32'(out0_valid), 32'd0);
        checkOutput("rst_out1_valid", 32'(out1_valid), 32'd0);
        checkOutput("rst_out0_data", out0_data, 32'd0);
        checkOutput("rst_out1_data", out1_data, 32'd0);
        checkOutput("rst_cnt0", 32'(cnt0), 32'd0);
        checkOutput("rst_cnt1", 32'(cnt1), 32'd0);

        // Basic routing and one-cycle latency
        applyStimulus(1, 0, 32'h11111111, 1, 1, 0);
        waitCheck();
        checkOutput("r_in_ready", 32'(in_ready), 32'd1);
        checkOutput("r_no_fallthru", 32'(out0_valid), 32'd0);
        applyStimulus(1, 1, 32'h22222222, 1, 1, 0);
        waitCheck();
        checkOutput("r_out0_first", out0_data, 32'h11111111);
        checkOutput("r_out1_empty", 32'(out1_valid), 32'd0);
        applyStimulus(1, 0, 32'h33333333, 1, 1, 0);
        waitCheck();
        checkOutput("r_out0_popped", 32'(out0_valid), 32'd0);
        checkOutput("r_out1_data", out1_data, 32'h22222222);
        applyStimulus(0, 0, 32'h0, 1, 1, 0);
        waitCheck();
        checkOutput("r_out0_second", out0_data, 32'h33333333);
        checkOutput("r_out1_drained", 32'(out1_valid), 32'd0);

        // Fill FIFO0 while its consumer stalls; FIFO1 still accepts
        applyStimulus(1, 0, 32'hA0, 0, 0, 0);
        waitCheck();
        checkOutput("f_cnt0_empty", 32'(cnt0), 32'd0);
        applyStimulus(1, 0, 32'hA1, 0, 0, 0);
        waitCheck();
        checkOutput("f_cnt0_one", 32'(cnt0), 32'd1);
        checkOutput("f_head_a0", out0_data, 32'hA0);
        applyStimulus(1, 0, 32'hDEAD, 0, 0, 0);
        waitCheck();
        checkOutput("f_cnt0_full", 32'(cnt0), 32'd2);
        checkOutput("f_ready_full", 32'(in_ready), 32'd0);
        applyStimulus(1, 1, 32'hB0, 0, 0, 0);
        waitCheck();
        checkOutput("f_ready_other", 32'(in_ready), 32'd1);

        // Full with pop pending: no pop-through, then push+pop keeps count
        applyStimulus(1, 0, 32'hBAD, 1, 0, 0);
        waitCheck();
        checkOutput("p_out1_b0", out1_data, 32'hB0);
        checkOutput("p_ready_full", 32'(in_ready), 32'd0);
        checkOutput("p_cnt0_two", 32'(cnt0), 32'd2);
        checkOutput("p_head_a0", out0_data, 32'hA0);
        applyStimulus(1, 0, 32'hC0, 1, 0, 0);
        waitCheck();
        checkOutput("p_cnt0_dec", 32'(cnt0), 32'd1);
        checkOutput("p_ready_ok", 32'(in_ready), 32'd1);
        checkOutput("p_head_a1", out0_data, 32'hA1);
        applyStimulus(0, 0, 32'h0, 0, 0, 0);
        waitCheck();
        checkOutput("p_cnt0_same", 32'(cnt0), 32'd1);
        checkOutput("p_head_c0", out0_data, 32'hC0);
        checkOutput("p_cnt1_one", 32'(cnt1), 32'd1);

        // Flush drops both FIFOs and the beat presented with it
        applyStimulus(1, 0, 32'hD0, 0, 0, 0);
        applyStimulus(1, 1, 32'hEE, 0, 0, 1);
        waitCheck();
        checkOutput("fl_cnt0_pre", 32'(cnt0), 32'd2);
        checkOutput("fl_cnt1_pre", 32'(cnt1), 32'd1);
        checkOutput("fl_ready", 32'(in_ready), 32'd0);
        applyStimulus(0, 0, 32'h0, 1, 1, 0);
        waitCheck();
        checkOutput("fl_cnt0", 32'(cnt0), 32'd0);
        checkOutput("fl_cnt1", 32'(cnt1), 32'd0);
        checkOutput("fl_v0", 32'(out0_valid), 32'd0);
        checkOutput("fl_v1", 32'(out1_valid), 32'd0);
        applyStimulus(0, 0, 32'h0, 1, 1, 0);
        waitCheck();
        checkOutput("fl_no_beat", 32'(out1_valid), 32'd0);

        // Asynchronous reset mid-cycle discards buffered data
        applyStimulus(1, 0, 32'h77, 0, 0, 0);
        applyStimulus(0, 0, 32'h0, 0, 0, 0);
        waitCheck();
        checkOutput("ar_cnt0_pre", 32'(cnt0), 32'd1);
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        checkOutput("ar_v0_async", 32'(out0_valid), 32'd0);
        checkOutput("ar_cnt0_async", 32'(cnt0), 32'd0);
        checkOutput("ar_d0_async", out0_data, 32'd0);
        @(posedge clk);
        #1 rst_n = 1;
        out0_ready = 1;
        repeat (2) waitCheck();
        checkOutput("ar_no_stale", 32'(out0_valid), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 39) == 0);
        end
        applyStimulus(0, 0, 32'h0, 1, 1, 0);
        repeat (4) waitCheck();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
